// File: rtl/sequenciador_host_caminho_pkg.sv
// Shared definitions for the host-side path-search sequencer.
// - Default parameter values for node address width, path FIFO depth and
//   the start-to-first-word timeout.
// - Sequencer state encoding (3-bit).
package sequenciador_host_caminho_pkg;

  localparam int ADDR_WIDTH_PADRAO     = 8;
  localparam int FIFO_DEPTH_PADRAO     = 64;
  localparam int TIMEOUT_CICLOS_PADRAO = 1048576;

  typedef enum logic [2:0] {
    OCIOSO   = 3'd0,
    INICIAR  = 3'd1,
    AGUARDAR = 3'd2,
    CAPTURAR = 3'd3,
    ENTREGAR = 3'd4,
    ERRO     = 3'd5
  } estado_t;

endpackage

// File: rtl/sequenciador_host_caminho_fifo.sv
// fifo_caminho: synchronous FIFO holding {last, addr} path entries.
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   limpar        synchronous flush (empties the FIFO)
//   push, pop     write / read requests; a push on a full FIFO is accepted
//                 only when a pop happens in the same cycle
//   data_in       entry to write
//   data_out      head entry, combinational
//   cheio, vazio  full / empty flags
module fifo_caminho #(
  parameter int DATA_WIDTH = 9,
  parameter int DEPTH      = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  limpar,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  cheio,
  output logic                  vazio
);

  localparam int PW = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]         rd_ptr;
  logic [PW-1:0]         wr_ptr;
  logic [PW:0]           count;
  logic                  wr_en;
  logic                  rd_en;

  assign vazio = (count == '0);
  assign cheio = (count == (PW+1)'(DEPTH));

  // A full FIFO still takes a write when the head leaves in the same cycle.
  assign wr_en = push & (~cheio | pop);
  assign rd_en = pop & ~vazio;

  assign data_out = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (limpar) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{PW{1'b0}}, wr_en} - {{PW{1'b0}}, rd_en};
    end
  end

  // NOTE: storage is deliberately left out of reset; the pointers and count
  // define what is valid, and the consumer masks the head while empty.
  always_ff @(posedge clk) begin
    if (wr_en && !limpar) mem[wr_ptr] <= data_in;
  end

endmodule

// File: rtl/sequenciador_host_caminho.sv
// sequenciador_host_caminho: host-side driver for the path-search core.
// - Forwards host obstacle writes to the core as registered one-cycle strobes.
// - On a host start, latches fonte/destino and sends one start pulse.
// - Captures path words (destino first, fonte last) into fifo_caminho and
//   presents them to the host with valid/ready; the fonte word carries last.
// - Flags timeout (no first word in time) and FIFO overflow in a sticky erro.
// Ports:
//   host_obst_*        obstacle write channel from the host (valid/ready)
//   host_start_in, host_fonte_in, host_destino_in   search request
//   host_ocupado_out, host_erro_out                  status
//   host_path_*        path word stream to the host (valid/ready/last)
//   top_*              start pulse and node addresses to the core
//   obstaculos_wr_*    registered obstacle write to the core
//   gma_*              path words from the anterior-memory manager
module sequenciador_host_caminho
  import sequenciador_host_caminho_pkg::*;
#(
  parameter int ADDR_WIDTH     = ADDR_WIDTH_PADRAO,
  parameter int FIFO_DEPTH     = FIFO_DEPTH_PADRAO,
  parameter int TIMEOUT_CICLOS = TIMEOUT_CICLOS_PADRAO
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  host_obst_valid_in,
  input  logic [ADDR_WIDTH-1:0] host_obst_addr_in,
  input  logic                  host_obst_data_in,
  output logic                  host_obst_ready_out,
  input  logic                  host_start_in,
  input  logic [ADDR_WIDTH-1:0] host_fonte_in,
  input  logic [ADDR_WIDTH-1:0] host_destino_in,
  output logic                  host_ocupado_out,
  output logic                  host_erro_out,
  output logic                  host_path_valid_out,
  output logic [ADDR_WIDTH-1:0] host_path_data_out,
  output logic                  host_path_last_out,
  input  logic                  host_path_ready_in,
  output logic                  top_wr_fonte_out,
  output logic [ADDR_WIDTH-1:0] top_addr_fonte_out,
  output logic [ADDR_WIDTH-1:0] top_addr_destino_out,
  output logic                  obstaculos_wr_enable_out,
  output logic [ADDR_WIDTH-1:0] obstaculos_wr_addr_out,
  output logic                  obstaculos_wr_data_out,
  input  logic [ADDR_WIDTH-1:0] gma_read_data_in,
  input  logic                  gma_pronto_in
);

  localparam int              CW         = $clog2(TIMEOUT_CICLOS) + 1;
  localparam logic [CW-1:0]   CNT_LIMITE = CW'(TIMEOUT_CICLOS - 1);
  localparam logic [CW-1:0]   CNT_MAX    = {CW{1'b1}};

  estado_t               estado;
  estado_t               prox_estado;
  logic [CW-1:0]         cnt;
  logic [ADDR_WIDTH-1:0] fonte_q;
  logic [ADDR_WIDTH-1:0] destino_q;
  logic                  erro_q;

  logic                  fifo_push;
  logic                  fifo_pop;
  logic                  fifo_limpar;
  logic                  fifo_cheio;
  logic                  fifo_vazio;
  logic [ADDR_WIDTH:0]   fifo_din;
  logic [ADDR_WIDTH:0]   fifo_dout;

  logic                  aceita_start;
  logic                  aceita_obst;
  logic                  palavra_fonte;

  assign aceita_start  = (estado == OCIOSO) & host_start_in;
  // Held low during reset so that every output reads 0 while rst is high.
  assign host_obst_ready_out = ~rst & (estado == OCIOSO) & ~host_start_in;
  assign aceita_obst   = host_obst_valid_in & host_obst_ready_out;
  assign palavra_fonte = (gma_read_data_in == fonte_q);
  assign fifo_pop      = ~fifo_vazio & host_path_ready_in;
  assign fifo_din      = {palavra_fonte, gma_read_data_in};

  fifo_caminho #(
    .DATA_WIDTH (ADDR_WIDTH + 1),
    .DEPTH      (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .limpar   (fifo_limpar),
    .push     (fifo_push),
    .pop      (fifo_pop),
    .data_in  (fifo_din),
    .data_out (fifo_dout),
    .cheio    (fifo_cheio),
    .vazio    (fifo_vazio)
  );

  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    prox_estado      = estado;
    fifo_push        = 1'b0;
    fifo_limpar      = 1'b0;
    top_wr_fonte_out = 1'b0;
    unique case (estado)
      OCIOSO: begin
        if (host_start_in) prox_estado = INICIAR;
      end
      INICIAR: begin
        top_wr_fonte_out = 1'b1;
        prox_estado      = AGUARDAR;
      end
      AGUARDAR: begin
        // FIFO is empty here, so the first word can never overflow. A first
        // word equal to fonte (fonte == destino) completes the path at once.
        if (gma_pronto_in) begin
          fifo_push   = 1'b1;
          prox_estado = palavra_fonte ? ENTREGAR : CAPTURAR;
        end else if (cnt >= CNT_LIMITE) begin
          prox_estado = ERRO;
        end
      end
      CAPTURAR: begin
        if (gma_pronto_in) begin
          if (fifo_cheio && !fifo_pop) begin
            prox_estado = ERRO;
          end else begin
            fifo_push = 1'b1;
            if (palavra_fonte) prox_estado = ENTREGAR;
          end
        end
      end
      ENTREGAR: begin
        if (fifo_pop && fifo_dout[ADDR_WIDTH]) prox_estado = OCIOSO;
      end
      ERRO: begin
        fifo_limpar = 1'b1;
        prox_estado = OCIOSO;
      end
      default: prox_estado = OCIOSO;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the values from before the edge, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      estado                   <= OCIOSO;
      cnt                      <= '0;
      fonte_q                  <= '0;
      destino_q                <= '0;
      erro_q                   <= 1'b0;
      obstaculos_wr_enable_out <= 1'b0;
      obstaculos_wr_addr_out   <= '0;
      obstaculos_wr_data_out   <= 1'b0;
    end else begin
      estado <= prox_estado;

      // Counts from the start pulse, so TIMEOUT_CICLOS cycles after the pulse
      // the sequencer is in ERRO. Saturates instead of wrapping.
      if (estado == INICIAR || estado == AGUARDAR) begin
        if (cnt != CNT_MAX) cnt <= cnt + 1'b1;
      end else begin
        cnt <= '0;
      end

      if (aceita_start) begin
        fonte_q   <= host_fonte_in;
        destino_q <= host_destino_in;
        erro_q    <= 1'b0;
      end else if (prox_estado == ERRO) begin
        erro_q <= 1'b1;
      end

      obstaculos_wr_enable_out <= aceita_obst;
      if (aceita_obst) begin
        obstaculos_wr_addr_out <= host_obst_addr_in;
        obstaculos_wr_data_out <= host_obst_data_in;
      end
    end
  end

  assign host_ocupado_out     = (estado != OCIOSO);
  assign host_erro_out        = erro_q;
  assign top_addr_fonte_out   = fonte_q;
  assign top_addr_destino_out = destino_q;
  assign host_path_valid_out  = ~fifo_vazio;
  // Head entry is masked while empty: the storage itself is not reset.
  assign host_path_data_out   = fifo_vazio ? '0 : fifo_dout[ADDR_WIDTH-1:0];
  assign host_path_last_out   = ~fifo_vazio & fifo_dout[ADDR_WIDTH];

endmodule

// File: tb/tb_sequenciador_host_caminho.sv
module tb_sequenciador_host_caminho;

  localparam int AW    = 8;
  localparam int DEPTH = 4;
  localparam int TMO   = 16;

  logic          clk;
  logic          rst;
  logic          obst_valid;
  logic [AW-1:0] obst_addr;
  logic          obst_data;
  logic          obst_ready;
  logic          start;
  logic [AW-1:0] fonte;
  logic [AW-1:0] destino;
  logic          ocupado;
  logic          erro;
  logic          path_valid;
  logic [AW-1:0] path_data;
  logic          path_last;
  logic          path_ready;
  logic          top_wr;
  logic [AW-1:0] top_fonte;
  logic [AW-1:0] top_destino;
  logic          obst_we;
  logic [AW-1:0] obst_we_addr;
  logic          obst_we_data;
  logic [AW-1:0] gma_data;
  logic          gma_pronto;

  sequenciador_host_caminho #(
    .ADDR_WIDTH     (AW),
    .FIFO_DEPTH     (DEPTH),
    .TIMEOUT_CICLOS (TMO)
  ) dut (
    .clk                      (clk),
    .rst                      (rst),
    .host_obst_valid_in       (obst_valid),
    .host_obst_addr_in        (obst_addr),
    .host_obst_data_in        (obst_data),
    .host_obst_ready_out      (obst_ready),
    .host_start_in            (start),
    .host_fonte_in            (fonte),
    .host_destino_in          (destino),
    .host_ocupado_out         (ocupado),
    .host_erro_out            (erro),
    .host_path_valid_out      (path_valid),
    .host_path_data_out       (path_data),
    .host_path_last_out       (path_last),
    .host_path_ready_in       (path_ready),
    .top_wr_fonte_out         (top_wr),
    .top_addr_fonte_out       (top_fonte),
    .top_addr_destino_out     (top_destino),
    .obstaculos_wr_enable_out (obst_we),
    .obstaculos_wr_addr_out   (obst_we_addr),
    .obstaculos_wr_data_out   (obst_we_data),
    .gma_read_data_in         (gma_data),
    .gma_pronto_in            (gma_pronto)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model of a search: the words the core sends (destino first,
  // fonte last) are exactly what the host must receive, last only on fonte.
  logic [AW-1:0] esperado[$];
  logic [AW-1:0] got_d[$];
  logic          got_l[$];

  typedef struct {
    logic          valid;
    logic [AW-1:0] addr;
    logic          data;
    logic          exp_ready;
    logic          exp_we;
  } obst_vec_t;

  obst_vec_t tabela[8];

  task automatic check(input string nome, input logic [31:0] atual, input logic [31:0] exp_v);
    n_cmp++;
    if (atual !== exp_v) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nome, atual, exp_v, $time);
    end
  endtask

  task automatic check_zero(input string p);
    check({p, "_obst_ready"}, obst_ready, 0);
    check({p, "_ocupado"}, ocupado, 0);
    check({p, "_erro"}, erro, 0);
    check({p, "_valid"}, path_valid, 0);
    check({p, "_data"}, path_data, 0);
    check({p, "_last"}, path_last, 0);
    check({p, "_top_wr"}, top_wr, 0);
    check({p, "_top_fonte"}, top_fonte, 0);
    check({p, "_top_destino"}, top_destino, 0);
    check({p, "_obst_we"}, obst_we, 0);
    check({p, "_obst_addr"}, obst_we_addr, 0);
    check({p, "_obst_data"}, obst_we_data, 0);
  endtask

  // Issues a start; ends at the falling edge inside the start-pulse cycle.
  task automatic start_search(input logic [AW-1:0] f, input logic [AW-1:0] d, input bit conflito);
    @(posedge clk); #1;
    start = 1'b1; fonte = f; destino = d;
    obst_valid = conflito; obst_addr = 8'hAA; obst_data = 1'b1;
    @(negedge clk);
    check("start_obst_ready", obst_ready, 0);
    @(posedge clk); #1;
    start = 1'b0; obst_valid = 1'b0;
    fonte = ~f; destino = ~d;
    @(negedge clk);
    check("pulse_top_wr", top_wr, 1);
    check("pulse_top_fonte", top_fonte, f);
    check("pulse_top_destino", top_destino, d);
    check("pulse_ocupado", ocupado, 1);
    check("pulse_erro_cleared", erro, 0);
    check("pulse_obst_we", obst_we, 0);
  endtask

  task automatic core_feed(input logic [AW-1:0] w[$], input int gap_max, input bit junk);
    int n;
    n = w.size() + (junk ? 1 : 0);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      gma_pronto = 1'b1;
      gma_data   = (i < w.size()) ? w[i] : AW'($urandom_range(0, 255));
      repeat ($urandom_range(0, gap_max)) begin
        @(posedge clk); #1;
        gma_pronto = 1'b0;
      end
    end
    @(posedge clk); #1;
    gma_pronto = 1'b0;
  endtask

  // mode 0: always ready; 1: random ready; 2: ready low for 10 cycles.
  task automatic host_collect(input int mode, input int budget);
    bit            done;
    bit            held;
    logic [AW-1:0] hd;
    logic          hl;
    done = 0; held = 0; hd = '0; hl = 1'b0;
    got_d.delete(); got_l.delete();
    for (int c = 0; c < budget && !done; c++) begin
      @(posedge clk); #1;
      case (mode)
        0:       path_ready = 1'b1;
        1:       path_ready = 1'($urandom_range(0, 1));
        default: path_ready = !(c >= 2 && c < 12);
      endcase
      @(negedge clk);
      if (path_valid && !path_ready) begin
        if (held) begin
          check("stall_data_stable", path_data, hd);
          check("stall_last_stable", path_last, hl);
        end
        held = 1; hd = path_data; hl = path_last;
      end else begin
        held = 0;
      end
      if (path_valid && path_ready) begin
        got_d.push_back(path_data);
        got_l.push_back(path_last);
        if (path_last) done = 1;
      end
    end
    @(posedge clk); #1;
    path_ready = 1'b0;
    check("collect_saw_last", done, 1);
  endtask

  task automatic compare_path(input string nome);
    int n;
    check({nome, "_len"}, got_d.size(), esperado.size());
    n = (got_d.size() < esperado.size()) ? got_d.size() : esperado.size();
    for (int i = 0; i < n; i++) begin
      check({nome, "_data"}, got_d[i], esperado[i]);
      check({nome, "_last"}, got_l[i], (i == esperado.size() - 1) ? 1 : 0);
    end
  endtask

  task automatic check_idle(input string nome, input logic exp_erro);
    @(negedge clk);
    check({nome, "_ocupado"}, ocupado, 0);
    check({nome, "_valid"}, path_valid, 0);
    check({nome, "_erro"}, erro, exp_erro);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [AW-1:0] f;
    logic [AW-1:0] d;
    logic [AW-1:0] w;
    logic [AW-1:0] ra;
    logic          rd;

    tabela[0] = '{1'b1, 8'd5,   1'b1, 1'b1, 1'b1};
    tabela[1] = '{1'b1, 8'd6,   1'b1, 1'b1, 1'b1};
    tabela[2] = '{1'b1, 8'd7,   1'b1, 1'b1, 1'b1};
    tabela[3] = '{1'b0, 8'h12,  1'b1, 1'b1, 1'b0};
    tabela[4] = '{1'b1, 8'h33,  1'b0, 1'b1, 1'b1};
    tabela[5] = '{1'b0, 8'h00,  1'b0, 1'b1, 1'b0};
    tabela[6] = '{1'b1, 8'hFF,  1'b1, 1'b1, 1'b1};
    tabela[7] = '{1'b1, 8'h00,  1'b0, 1'b1, 1'b1};

    rst = 1'b1; obst_valid = 1'b0; obst_addr = '0; obst_data = 1'b0;
    start = 1'b0; fonte = '0; destino = '0; path_ready = 1'b0;
    gma_data = '0; gma_pronto = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    check_zero("reset");
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("idle_obst_ready", obst_ready, 1);

    // Obstacle writes from the table, strobe one cycle later
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      obst_valid = tabela[i].valid;
      obst_addr  = tabela[i].addr;
      obst_data  = tabela[i].data;
      @(negedge clk);
      check("tab_ready", obst_ready, tabela[i].exp_ready);
      if (i > 0) begin
        check("tab_we", obst_we, tabela[i-1].exp_we);
        if (tabela[i-1].exp_we) begin
          check("tab_addr", obst_we_addr, tabela[i-1].addr);
          check("tab_data", obst_we_data, tabela[i-1].data);
        end
      end
    end
    @(posedge clk); #1;
    obst_valid = 1'b0;
    @(negedge clk);
    check("tab_we", obst_we, tabela[7].exp_we);
    check("tab_addr", obst_we_addr, tabela[7].addr);
    @(negedge clk);
    check("tab_we_single", obst_we, 0);

    // Path words while idle are ignored
    @(posedge clk); #1;
    gma_pronto = 1'b1; gma_data = 8'h55;
    @(posedge clk); #1;
    gma_pronto = 1'b0;
    @(negedge clk);
    check("idle_pronto_valid", path_valid, 0);
    check("idle_pronto_ocupado", ocupado, 0);

    // Normal path fonte=2, destino=9
    esperado = '{8'd9, 8'd4, 8'd3, 8'd2};
    start_search(8'd2, 8'd9, 1'b0);
    fork
      core_feed(esperado, 0, 1'b0);
      host_collect(0, 100);
    join
    compare_path("normal");
    check_idle("normal_end", 1'b0);

    // Backpressure mid-path
    esperado = '{8'd20, 8'd15, 8'd11, 8'd1};
    start_search(8'd1, 8'd20, 1'b0);
    fork
      core_feed(esperado, 1, 1'b1);
      host_collect(2, 100);
    join
    compare_path("backpressure");
    check_idle("backpressure_end", 1'b0);

    // Timeout: erro appears TMO cycles after the start pulse
    start_search(8'd3, 8'd4, 1'b0);
    for (int j = 1; j <= TMO; j++) begin
      @(negedge clk);
      check("timeout_erro", erro, (j == TMO) ? 1 : 0);
      check("timeout_ocupado", ocupado, 1);
      if (j == 1) check("pulse_single_cycle", top_wr, 0);
    end
    @(negedge clk);
    check("timeout_back_idle", ocupado, 0);
    check("timeout_fifo_empty", path_valid, 0);
    check("timeout_erro_sticky", erro, 1);

    // fonte == destino with a conflicting obstacle write; start clears erro
    esperado = '{8'd7};
    start_search(8'd7, 8'd7, 1'b1);
    fork
      core_feed(esperado, 0, 1'b0);
      host_collect(0, 100);
    join
    compare_path("single_word");
    check_idle("single_word_end", 1'b0);

    // Overflow: host stalled, DEPTH+1 words without fonte
    start_search(8'd50, 8'd60, 1'b0);
    for (int i = 0; i <= DEPTH; i++) begin
      @(posedge clk); #1;
      gma_pronto = 1'b1; gma_data = AW'(60 + i);
      @(negedge clk);
      check("ovf_erro_before", erro, 0);
      if (i > 0) begin
        check("ovf_valid", path_valid, 1);
        check("ovf_head", path_data, 60);
      end
    end
    @(posedge clk); #1;
    gma_pronto = 1'b0;
    @(negedge clk);
    check("ovf_erro", erro, 1);
    check("ovf_ocupado", ocupado, 1);
    @(negedge clk);
    check("ovf_idle", ocupado, 0);
    check("ovf_flushed", path_valid, 0);
    check("ovf_erro_sticky", erro, 1);

    // Randomized searches against the path model
    for (int it = 0; it < 20; it++) begin
      ra = AW'($urandom_range(0, 255));
      rd = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      obst_valid = 1'b1; obst_addr = ra; obst_data = rd;
      @(posedge clk); #1;
      obst_valid = 1'b0;
      @(negedge clk);
      check("rnd_obst_we", obst_we, 1);
      check("rnd_obst_addr", obst_we_addr, ra);
      check("rnd_obst_data", obst_we_data, rd);

      f = AW'($urandom_range(0, 255));
      d = ($urandom_range(0, 3) == 0) ? f : AW'($urandom_range(0, 255));
      esperado.delete();
      esperado.push_back(d);
      if (d != f) begin
        repeat ($urandom_range(0, 2)) begin
          do w = AW'($urandom_range(0, 255)); while (w == f);
          esperado.push_back(w);
        end
        esperado.push_back(f);
      end
      start_search(f, d, 1'($urandom_range(0, 1)));
      fork
        core_feed(esperado, 3, 1'($urandom_range(0, 1)));
        host_collect($urandom_range(0, 2), 300);
      join
      compare_path("rnd");
      check_idle("rnd_end", 1'b0);
    end

    // Start outside OCIOSO ignored, then reset in the middle of capture
    start_search(8'd100, 8'd101, 1'b0);
    @(posedge clk); #1;
    gma_pronto = 1'b1; gma_data = 8'd101;
    @(posedge clk); #1;
    gma_data = 8'd102;
    start = 1'b1; fonte = 8'd9; destino = 8'd9;
    @(posedge clk); #1;
    gma_pronto = 1'b0; start = 1'b0;
    @(negedge clk);
    check("busy_start_ignored_wr", top_wr, 0);
    check("busy_start_ignored_fonte", top_fonte, 100);
    check("mid_capture_valid", path_valid, 1);
    #2 rst = 1'b1;
    #1 check_zero("rst_mid");
    @(posedge clk); #1;
    rst = 1'b0;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      check("post_rst_top_wr", top_wr, 0);
      check("post_rst_ocupado", ocupado, 0);
      check("post_rst_valid", path_valid, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
